time_field_editor: RTL and testbench

Parametrised multi-field time editor for alarm and timer setting. It generalises single min/sec editing to NUM_FIELDS fields, each with its own wrap limit. Edits come from a 4-key pad and support hold-to-repeat, preload from the running clock, and commit. It sits between the key input block and the alarm compare/display logic.

---
 rtl/time_field_editor.sv | 212 +++++++++++++++++++++
 tb/tb_time_field_editor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_field_editor.sv
// Multi-field time editor driven by a 4-key pad (inc/dec/next/commit) with hold-to-repeat and preload.
// Optional feature macro REPEAT_ACCEL_EN: after 8 repeat steps the repeat interval shrinks to REPEAT_CYCLES/4.
module time_field_editor #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 7,
  parameter int SEL_W = 2,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = {7'd23, 7'd59, 7'd59},
  parameter int HOLD_CYCLES = 1000000,
  parameter int REPEAT_CYCLES = 200000
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          EDIT_EN,
  input  logic [3:0]                    KEY,
  input  logic                          LOAD,
  input  logic [NUM_FIELDS*FIELD_W-1:0] LOAD_VALUE,
  output logic [NUM_FIELDS*FIELD_W-1:0] FIELDS,
  output logic [SEL_W-1:0]              SEL,
  output logic                          CHANGED,
  output logic                          COMMIT,
  output logic                          HELD,
  output logic [1:0]                    STATE_DBG
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int FW_ALL = NUM_FIELDS * FIELD_W;
`ifdef REPEAT_ACCEL_EN
  localparam int ACC_CYCLES = (REPEAT_CYCLES / 4 > 0) ? REPEAT_CYCLES / 4 : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESSED      = 2'd1,
    S_REPEAT       = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         key_meta, key_s;
  logic [3:0]         key_lat_q, key_lat_d;
  logic [1:0]         sync_fill;
  logic               armed_q;
  logic [FW_ALL-1:0]  fields_q, fields_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               changed_q, changed_d;
  logic               commit_q, commit_d;
  logic               do_step;
  logic               one_hot;
  logic               rep_last;

  function automatic logic [FIELD_W-1:0] step_field(input logic [FIELD_W-1:0] f,
                                                    input logic [FIELD_W-1:0] mx,
                                                    input logic up);
    if (up) return (f >= mx) ? '0 : f + 1'b1;
    else    return (f == '0) ? mx : f - 1'b1;
  endfunction

  // armed_q stays low until the synchroniser holds real samples and EDIT_EN has been
  // high for a cycle, so a key already held at reset release or enable is ignored.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      key_meta  <= '0;
      key_s     <= '0;
      sync_fill <= '0;
      armed_q   <= 1'b0;
    end else begin
      key_meta  <= KEY;
      key_s     <= key_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed_q   <= EDIT_EN & sync_fill[1];
    end
  end

  assign one_hot = (key_s != 4'd0) && ((key_s & (key_s - 4'd1)) == 4'd0);

`ifdef REPEAT_ACCEL_EN
  logic [3:0] rep_q, rep_d;

  assign rep_last = (rep_q == 4'd8) ? (cnt_q == CNT_W'(ACC_CYCLES - 1))
                                    : (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

  always_comb begin
    rep_d = rep_q;
    if (state_d != S_REPEAT)
      rep_d = 4'd0;
    else if (state_q == S_REPEAT && do_step && rep_q != 4'd8)
      rep_d = rep_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) rep_q <= 4'd0;
    else         rep_q <= rep_d;
  end
`else
  assign rep_last = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_lat_d = key_lat_q;
    sel_d     = sel_q;
    do_step   = 1'b0;
    commit_d  = 1'b0;
    if (!EDIT_EN || key_s == 4'd0) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!armed_q) begin
      state_d = S_WAIT_RELEASE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!one_hot) begin
            state_d = S_WAIT_RELEASE;
          end else if (key_s[3] || key_s[2]) begin
            key_lat_d = key_s;
            do_step   = 1'b1;
            state_d   = S_PRESSED;
          end else if (key_s[1]) begin
            sel_d   = (sel_q == SEL_W'(NUM_FIELDS - 1)) ? '0 : sel_q + 1'b1;
            state_d = S_WAIT_RELEASE;
          end else begin
            commit_d = 1'b1;
            sel_d    = '0;
            state_d  = S_WAIT_RELEASE;
          end
        end
        S_PRESSED: begin
          if (key_s != key_lat_q) begin
            state_d = S_WAIT_RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (key_s != key_lat_q) begin
            state_d = S_WAIT_RELEASE;
            cnt_d   = '0;
          end else if (rep_last) begin
            do_step = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_WAIT_RELEASE;
      endcase
    end
    changed_d = do_step;
    // Preload wins over anything the keypad asked for in the same cycle.
    if (LOAD) begin
      sel_d     = '0;
      cnt_d     = '0;
      state_d   = (key_s != 4'd0) ? S_WAIT_RELEASE : S_IDLE;
      changed_d = 1'b0;
      commit_d  = 1'b0;
    end
  end

  always_comb begin
    fields_d = fields_q;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (LOAD) begin
        fields_d[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W] =
          (LOAD_VALUE[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W] > FIELD_MAX[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W])
            ? FIELD_MAX[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W]
            : LOAD_VALUE[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W];
      end else if (do_step && sel_q == SEL_W'(i)) begin
        fields_d[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W] =
          step_field(fields_q[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W],
                     FIELD_MAX[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W], key_s[3]);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_lat_q <= '0;
      fields_q  <= '0;
      sel_q     <= '0;
      changed_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_lat_q <= key_lat_d;
      fields_q  <= fields_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
      commit_q  <= commit_d;
    end
  end

  assign FIELDS    = fields_q;
  assign SEL       = sel_q;
  assign CHANGED   = changed_q;
  assign COMMIT    = commit_q;
  assign HELD      = (state_q == S_REPEAT);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_time_field_editor.sv
// Bench for time_field_editor: directed and randomised key sequences checked against a field-level model.
module tb_time_field_editor;
  localparam int NF = 3;
  localparam int FW = 7;
  localparam int SW = 2;
  localparam int W = NF * FW;
  localparam int HOLD = 10;
  localparam int REP = 4;
`ifdef REPEAT_ACCEL_EN
  localparam int ACC = (REP / 4 > 0) ? REP / 4 : 1;
`endif

  // clock / reset
  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          EDIT_EN = 1'b0;
  logic [3:0]    KEY = 4'd0;
  logic          LOAD = 1'b0;
  logic [W-1:0]  LOAD_VALUE = '0;
  logic [W-1:0]  FIELDS;
  logic [SW-1:0] SEL;
  logic          CHANGED, COMMIT, HELD;
  logic [1:0]    STATE_DBG;

  always #5 CLK = ~CLK;

  time_field_editor #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .SEL_W(SW),
    .FIELD_MAX({7'd23, 7'd59, 7'd59}),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .EDIT_EN(EDIT_EN), .KEY(KEY),
    .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE), .FIELDS(FIELDS), .SEL(SEL),
    .CHANGED(CHANGED), .COMMIT(COMMIT), .HELD(HELD), .STATE_DBG(STATE_DBG)
  );

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int overlap = 0;
  int chg_q[$];
  int com_q[$];
  int held_q[$];
  logic [31:0] exp_q[$];
  int m_f[NF];
  int m_sel = 0;
  int fmax[NF] = '{23, 59, 59};

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (CHANGED) chg_q.push_back(cyc);
    if (COMMIT) com_q.push_back(cyc);
    if (HELD) held_q.push_back(cyc);
    if (CHANGED && COMMIT) overlap++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack3(input int a, input int b, input int c);
    logic [W-1:0] r;
    r = {a[FW-1:0], b[FW-1:0], c[FW-1:0]};
    return r;
  endfunction

  function automatic logic [W-1:0] m_pack();
    return pack3(m_f[0], m_f[1], m_f[2]);
  endfunction

  // model: each field counts modulo (max+1); no carry into neighbours
  function automatic void model_step(input logic up);
    int m;
    m = fmax[m_sel] + 1;
    m_f[m_sel] = up ? (m_f[m_sel] + 1) % m : (m_f[m_sel] + m - 1) % m;
  endfunction

  // step offsets (cycles after the first acting edge) for a key held for n edges
  function automatic void plan_steps(input int n);
    int t;
`ifdef REPEAT_ACCEL_EN
    int done;
    done = 0;
`endif
    exp_q.delete();
    exp_q.push_back(0);
    t = HOLD;
    while (t <= n - 1) begin
      exp_q.push_back(t);
`ifdef REPEAT_ACCEL_EN
      if (t != HOLD) done++;
      t += (done >= 8) ? ACC : REP;
`else
      t += REP;
`endif
    end
  endfunction

  task automatic clear_logs();
    chg_q.delete();
    com_q.delete();
    held_q.delete();
  endtask

  // driver tasks
  task automatic do_hold(input logic [3:0] key, input int n, input string tag);
    int c0;
    clear_logs();
    c0 = cyc;
    KEY = key;
    repeat (n) tick();
    KEY = 4'd0;
    repeat (4) tick();
    plan_steps(n);
    foreach (exp_q[i]) model_step(key[3]);
    chk({tag, "_nsteps"}, chg_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < chg_q.size(); i++)
      chk({tag, "_step_time"}, chg_q[i] - c0 - 3, exp_q[i]);
    chk({tag, "_held_cycles"}, held_q.size(), (n > HOLD) ? n - HOLD : 0);
    if (held_q.size() > 0) chk({tag, "_held_first"}, held_q[0] - c0 - 3, HOLD);
    chk({tag, "_fields"}, FIELDS, m_pack());
    chk({tag, "_held_after"}, HELD, 0);
  endtask

  task automatic do_tap(input logic [3:0] key, input string tag);
    int ncom;
    clear_logs();
    ncom = 0;
    KEY = key;
    repeat (3) tick();
    KEY = 4'd0;
    repeat (4) tick();
    if (key == 4'b0010) m_sel = (m_sel + 1) % NF;
    if (key == 4'b0001) begin
      m_sel = 0;
      ncom = 1;
    end
    chk({tag, "_sel"}, SEL, m_sel);
    chk({tag, "_fields"}, FIELDS, m_pack());
    chk({tag, "_changed"}, chg_q.size(), 0);
    chk({tag, "_commit"}, com_q.size(), ncom);
  endtask

  task automatic do_load(input int a, input int b, input int c, input string tag);
    int v[NF];
    clear_logs();
    v = '{a, b, c};
    LOAD_VALUE = pack3(a, b, c);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    tick();
    for (int i = 0; i < NF; i++) m_f[i] = (v[i] < fmax[i]) ? v[i] : fmax[i];
    m_sel = 0;
    chk({tag, "_fields"}, FIELDS, m_pack());
    chk({tag, "_sel"}, SEL, 0);
    chk({tag, "_changed"}, chg_q.size(), 0);
  endtask

  initial begin
    int n;
    m_f = '{0, 0, 0};

    repeat (3) tick();
    chk("reset_fields", FIELDS, 0);
    chk("reset_sel", SEL, 0);
    chk("reset_changed", CHANGED, 0);
    chk("reset_commit", COMMIT, 0);
    chk("reset_held", HELD, 0);
    RESETN = 1'b1;
    EDIT_EN = 1'b1;
    repeat (5) tick();

    // first tap: FIELDS moves exactly on the third edge after KEY
    clear_logs();
    KEY = 4'b1000;
    tick();
    tick();
    chk("latency_edge2", FIELDS, 0);
    tick();
    model_step(1'b1);
    chk("latency_edge3", FIELDS, m_pack());
    KEY = 4'd0;
    repeat (4) tick();
    chk("tap_inc_pulses", chg_q.size(), 1);
    chk("tap_inc_held", held_q.size(), 0);

    // wrap boundaries
    do_load(23, 10, 59, "load_a");
    do_tap(4'b0010, "next_a");
    do_tap(4'b0010, "next_b");
    do_hold(4'b1000, 3, "wrap_inc_f2");
    do_hold(4'b0100, 3, "wrap_dec_f2");
    do_tap(4'b0010, "next_c");
    do_hold(4'b1000, 3, "wrap_inc_f0");

    do_load(30, 45, 70, "load_clamp");
    do_hold(4'b1000, 40, "hold40");
    do_hold(4'b0100, 60, "hold60");

    do_tap(4'b0010, "next_1");
    do_tap(4'b0010, "next_2");
    do_tap(4'b0010, "next_0");
    do_tap(4'b1010, "multi_key");
    do_tap(4'b0010, "next_pre_commit");
    do_tap(4'b0001, "commit");

    // LOAD on the same edge as an inc step
    clear_logs();
    KEY = 4'b1000;
    tick();
    tick();
    LOAD_VALUE = pack3(5, 61, 3);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    KEY = 4'd0;
    repeat (5) tick();
    m_f = '{5, 59, 3};
    m_sel = 0;
    chk("load_vs_step_fields", FIELDS, m_pack());
    chk("load_vs_step_changed", chg_q.size(), 0);
    chk("load_vs_step_sel", SEL, 0);

    // randomised loads, selects and holds
    for (int r = 0; r < 6; r++) begin
      do_load($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), "rnd_load");
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) do_tap(4'b0010, "rnd_next");
      do_hold(($urandom_range(0, 1) == 1) ? 4'b1000 : 4'b0100, $urandom_range(3, 30), "rnd_hold");
    end

    // editing disabled for the whole hold
    clear_logs();
    EDIT_EN = 1'b0;
    KEY = 4'b1000;
    repeat (20) tick();
    KEY = 4'd0;
    repeat (4) tick();
    chk("en_off_changed", chg_q.size(), 0);
    chk("en_off_fields", FIELDS, m_pack());
    EDIT_EN = 1'b1;
    repeat (3) tick();

    // disable mid-hold, re-enable while still held
    clear_logs();
    KEY = 4'b1000;
    repeat (5) tick();
    EDIT_EN = 1'b0;
    repeat (15) tick();
    EDIT_EN = 1'b1;
    repeat (15) tick();
    KEY = 4'd0;
    repeat (4) tick();
    model_step(1'b1);
    chk("en_toggle_changed", chg_q.size(), 1);
    chk("en_toggle_fields", FIELDS, m_pack());

    // asynchronous reset in the middle of auto-repeat
    KEY = 4'b1000;
    repeat (20) tick();
    chk("pre_reset_held", HELD, 1);
    RESETN = 1'b0;
    #1;
    chk("async_fields", FIELDS, 0);
    chk("async_sel", SEL, 0);
    chk("async_changed", CHANGED, 0);
    chk("async_commit", COMMIT, 0);
    chk("async_held", HELD, 0);
    repeat (2) tick();
    clear_logs();
    RESETN = 1'b1;
    repeat (15) tick();
    KEY = 4'd0;
    repeat (4) tick();
    chk("post_reset_changed", chg_q.size(), 0);
    chk("post_reset_fields", FIELDS, 0);

    chk("changed_commit_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
